// File: rtl/merge_pass_ctrl.sv
// Purpose: sequences the bottom-up merge-sort passes, launching one merge job per run pair (optional abort input when MERGE_CTRL_ABORT_EN is defined).
// Latency: start -> merge_start 1 cycle; merge_done -> merge_start 1 cycle (2 across a pass boundary); final merge_done -> done 1 cycle.
// Backpressure: waits in WAIT without limit until merge_done; start is ignored while busy.
module merge_pass_ctrl #(
  parameter int N_LEN  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              merge_done,
`ifdef MERGE_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              merge_start,
  output logic [ADDR_W-1:0] l_base,
  output logic [ADDR_W-1:0] r_base,
  output logic [ADDR_W-1:0] run_len,
  output logic              src_buf,
  output logic [ADDR_W-1:0] pass_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  // N_LEN itself does not fit in ADDR_W bits, so the end-of-pass test
  // is done one bit wider than the address path.
  localparam logic [ADDR_W:0]   LEN_W = (ADDR_W+1)'(N_LEN);
  localparam logic [ADDR_W-1:0] HALF  = ADDR_W'(N_LEN / 2);

  logic [2:0]        state;
  logic [ADDR_W:0]   next_l_wide;
  logic [ADDR_W-1:0] next_l;
  logic              last_job;
  logic              last_pass;

  // Left base of the following pair and the end-of-pass / end-of-sort tests.
  always_comb begin
    next_l_wide = {1'b0, l_base} + {run_len, 1'b0};
    next_l      = next_l_wide[ADDR_W-1:0];
    last_job    = (next_l_wide >= LEN_W);
    last_pass   = (run_len == HALF);
  end

  // Pass/job sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      merge_start <= 1'b0;
      l_base      <= '0;
      r_base      <= '0;
      run_len     <= '0;
      src_buf     <= 1'b0;
      pass_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end
`ifdef MERGE_CTRL_ABORT_EN
    else if (abort && (state != S_IDLE)) begin
      state       <= S_IDLE;
      merge_start <= 1'b0;
      l_base      <= '0;
      r_base      <= '0;
      run_len     <= '0;
      src_buf     <= 1'b0;
      pass_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end
`endif
    else begin
      merge_start <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            run_len     <= ADDR_W'(1);
            l_base      <= '0;
            r_base      <= ADDR_W'(1);
            pass_cnt    <= '0;
            src_buf     <= 1'b0;
            merge_start <= 1'b1;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (merge_done) begin
            if (!last_job) begin
              l_base      <= next_l;
              r_base      <= next_l + run_len;
              merge_start <= 1'b1;
              state       <= S_ISSUE;
            end else if (last_pass) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          run_len     <= run_len << 1;
          src_buf     <= ~src_buf;
          pass_cnt    <= pass_cnt + ADDR_W'(1);
          l_base      <= '0;
          r_base      <= run_len << 1;
          merge_start <= 1'b1;
          state       <= S_ISSUE;
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_merge_pass_ctrl.sv
module tb_merge_pass_ctrl;
  localparam int N8 = 8;
  localparam int NJ = N8 - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, md;
  logic       ms, src, busy, done;
  logic [2:0] lb, rb, rl, pc;
  logic       start2, md2;
  logic       ms2, src2, busy2, done2;
  logic [0:0] lb2, rb2, rl2, pc2;
`ifdef MERGE_CTRL_ABORT_EN
  logic       abort, abort2;
`endif

  int total = 0;
  int bad   = 0;
  int ms_cnt = 0;

  // reference job list built from the sort's definition
  int e_l[NJ], e_r[NJ], e_len[NJ], e_pass[NJ], e_lat[NJ];

  merge_pass_ctrl #(.N_LEN(8), .ADDR_W(3)) dut8 (
    .clk(clk), .rst(rst), .start(start), .merge_done(md),
`ifdef MERGE_CTRL_ABORT_EN
    .abort(abort),
`endif
    .merge_start(ms), .l_base(lb), .r_base(rb), .run_len(rl),
    .src_buf(src), .pass_cnt(pc), .busy(busy), .done(done)
  );

  merge_pass_ctrl #(.N_LEN(2), .ADDR_W(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .merge_done(md2),
`ifdef MERGE_CTRL_ABORT_EN
    .abort(abort2),
`endif
    .merge_start(ms2), .l_base(lb2), .r_base(rb2), .run_len(rl2),
    .src_buf(src2), .pass_cnt(pc2), .busy(busy2), .done(done2)
  );

  always @(posedge clk) if (ms === 1'b1) ms_cnt <= ms_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".merge_start"}, ms, 0);
    chk({tag, ".l_base"}, lb, 0);
    chk({tag, ".r_base"}, rb, 0);
    chk({tag, ".run_len"}, rl, 0);
    chk({tag, ".pass_cnt"}, pc, 0);
    chk({tag, ".src_buf"}, src, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
  endtask

  // wait (bounded) for merge_start; lat = cycles waited, 99 on timeout
  task automatic wait_ms(input bit clr_md, output int lat);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (clr_md) md = 1'b0;
      if (ms === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // mode: 0 fixed delay 3, 1 random delay, 2 start/merge_done noise,
  //       3 reset in WAIT of pass 1, 4 abort during job 5, 5 100-cycle stall
  task automatic run_sort(input int mode);
    int lat, d, c0;
    c0 = ms_cnt;
    start = 1'b1;
    md = (mode == 2);
    for (int j = 0; j < NJ; j++) begin
      wait_ms(mode != 2, lat);
      chk($sformatf("m%0d.lat[%0d]", mode, j), lat, e_lat[j]);
      chk($sformatf("m%0d.l_base[%0d]", mode, j), lb, e_l[j]);
      chk($sformatf("m%0d.r_base[%0d]", mode, j), rb, e_r[j]);
      chk($sformatf("m%0d.run_len[%0d]", mode, j), rl, e_len[j]);
      chk($sformatf("m%0d.pass_cnt[%0d]", mode, j), pc, e_pass[j]);
      chk($sformatf("m%0d.src_buf[%0d]", mode, j), src, e_pass[j] % 2);
      chk($sformatf("m%0d.busy_issue[%0d]", mode, j), busy, 1);
      if (mode != 2) start = 1'b0;
      d = (mode == 1) ? int'($urandom_range(1, 6)) : ((mode == 5 && j == 2) ? 100 : 3);
      for (int k = 1; k <= d; k++) begin
        @(negedge clk);
        if (mode == 2 && k == 1) md = 1'b0;
        chk($sformatf("m%0d.ms_low[%0d]", mode, j), ms, 0);
        chk($sformatf("m%0d.busy_wait[%0d]", mode, j), busy, 1);
        if (mode == 3 && j == 4 && k == 2) begin
          rst = 1'b0;
          #1;
          chk_all_zero("rst_mid");
          @(negedge clk);
          rst = 1'b1;
          return;
        end
`ifdef MERGE_CTRL_ABORT_EN
        if (mode == 4 && j == 4 && k == 2) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk_all_zero("abort");
          @(negedge clk);
          chk("abort.no_done", done, 0);
          return;
        end
`endif
      end
      if (mode == 2 && j == NJ - 1) start = 1'b0;
      md = 1'b1;
    end
    @(negedge clk);
    if (mode != 2) md = 1'b0;
    chk($sformatf("m%0d.done", mode), done, 1);
    chk($sformatf("m%0d.busy_fin", mode), busy, 1);
    chk($sformatf("m%0d.ms_fin", mode), ms, 0);
    @(negedge clk);
    md = 1'b0;
    chk($sformatf("m%0d.done_pulse", mode), done, 0);
    chk($sformatf("m%0d.busy_idle", mode), busy, 0);
    chk($sformatf("m%0d.held_l", mode), lb, e_l[NJ-1]);
    chk($sformatf("m%0d.held_r", mode), rb, e_r[NJ-1]);
    chk($sformatf("m%0d.held_len", mode), rl, e_len[NJ-1]);
    chk($sformatf("m%0d.held_pass", mode), pc, e_pass[NJ-1]);
    chk($sformatf("m%0d.ms_count", mode), ms_cnt - c0, NJ);
  endtask

  initial begin
    int k, p;
    k = 0;
    p = 0;
    for (int len = 1; len < N8; len *= 2) begin
      for (int l = 0; l < N8; l += 2 * len) begin
        e_l[k]    = l;
        e_r[k]    = l + len;
        e_len[k]  = len;
        e_pass[k] = p;
        e_lat[k]  = (k != 0 && l == 0) ? 2 : 1;
        k++;
      end
      p++;
    end

    rst = 1'b0; start = 1'b0; md = 1'b0; start2 = 1'b0; md2 = 1'b0;
`ifdef MERGE_CTRL_ABORT_EN
    abort = 1'b0; abort2 = 1'b0;
`endif
    #2;
    chk_all_zero("reset");
    chk("reset.busy2", busy2, 0);
    @(negedge clk);
    chk_all_zero("reset_edge");
    rst = 1'b1;

    run_sort(0);

    // two-element sort: one job, single pass
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("n2.ms", ms2, 1);
    chk("n2.l_base", lb2, 0);
    chk("n2.r_base", rb2, 1);
    chk("n2.run_len", rl2, 1);
    chk("n2.pass_cnt", pc2, 0);
    chk("n2.busy", busy2, 1);
    @(negedge clk);
    chk("n2.ms_low", ms2, 0);
    md2 = 1'b1;
    @(negedge clk);
    md2 = 1'b0;
    chk("n2.done", done2, 1);
    chk("n2.pass_fin", pc2, 0);
    @(negedge clk);
    chk("n2.done_pulse", done2, 0);
    chk("n2.busy_idle", busy2, 0);

    for (int r = 0; r < 3; r++) run_sort(1);
    run_sort(2);
    run_sort(5);
    run_sort(3);
    run_sort(0);
`ifdef MERGE_CTRL_ABORT_EN
    run_sort(4);
    run_sort(0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
